// File: rtl/sound_pkg.sv
// sound_pkg: shared state encodings, source indices and counter sizing helpers for sound_sched.
package sound_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ON    = 3'd1;
  localparam logic [2:0] ST_OFF   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;
  localparam logic [1:0] SRC_ALARM = 2'd0;
  localparam logic [1:0] SRC_WALK  = 2'd1;
  localparam logic [1:0] SRC_ACK   = 2'd2;
  function automatic int ms_div(input int clk_frq);
    return clk_frq / 1000;
  endfunction
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ms_tick.sv
// ms_tick: millisecond prescaler; restart_i zeroes it so the first tick lands a full period later.
module ms_tick
  import sound_pkg::*;
#(
  parameter int C_DIV = 100_000
) (
  input  logic clk,
  input  logic rstb,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = cnt_w(C_DIV);
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(C_DIV - 1);
  always_ff @(posedge clk)
    if (!rstb || restart_i) cnt_q <= '0;
    else cnt_q <= tick_o ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/sound_sched.sv
// sound_sched: arbitrates alarm/walk/ack beep requests and drives the tone enable with an on/off cadence.
module sound_sched
  import sound_pkg::*;
#(
  parameter int C_CLK_FRQ = 100_000_000,
  parameter int C_ON_MS   = 200,
  parameter int C_OFF_MS  = 200,
  parameter int C_GAP_MS  = 500,
  parameter int C_NBEEP_1 = 3,
  parameter int C_NBEEP_2 = 1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [2:0] req,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] done
);
  localparam int MS_MAX = (C_ON_MS > C_OFF_MS ? (C_ON_MS > C_GAP_MS ? C_ON_MS : C_GAP_MS)
                                              : (C_OFF_MS > C_GAP_MS ? C_OFF_MS : C_GAP_MS));
  localparam int MW = cnt_w(MS_MAX);
  logic [2:0]    state_q, state_d;
  logic [1:0]    src_q, src_d;
  logic [3:0]    nb_q, nb_d;
  logic [MW-1:0] ms_q, ms_d, lim;
  logic [2:0]    req_q, done_d;
  logic [2:1]    pend_q, pend_d, rise, take;
  logic [3:0]    nbeep;
  logic          tick, restart, expired;
  ms_tick #(.C_DIV(ms_div(C_CLK_FRQ))) u_ms_tick (
    .clk      (clk),
    .rstb     (rstb),
    .restart_i(restart),
    .tick_o   (tick)
  );
  assign lim     = state_q == ST_ON ? MW'(C_ON_MS - 1) : state_q == ST_OFF ? MW'(C_OFF_MS - 1) : MW'(C_GAP_MS - 1);
  assign expired = tick && ms_q == lim;
  assign nbeep   = src_q == SRC_WALK ? 4'(C_NBEEP_1) : 4'(C_NBEEP_2);
  assign restart = state_d != state_q;
  assign ms_d    = restart ? '0 : ms_q + MW'(tick);
  assign rise    = req[2:1] & ~req_q[2:1];
  assign take    = {state_q == ST_IDLE && state_d == ST_ON && src_d == SRC_ACK,
                    state_q == ST_IDLE && state_d == ST_ON && src_d == SRC_WALK};
  // a fresh edge wins over the grant-clear so a request landing on the grant cycle is not dropped
  assign pend_d  = rise | (pend_q & ~take);
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    nb_d    = nb_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE:
        if (req_q[0]) begin
          state_d = ST_ALARM;
          src_d   = SRC_ALARM;
        end else if (pend_q[1] || pend_q[2]) begin
          state_d = ST_ON;
          src_d   = pend_q[1] ? SRC_WALK : SRC_ACK;
          nb_d    = 4'd1;
        end
      ST_ON, ST_OFF:
        if (req_q[0]) begin
          state_d = ST_ALARM;
          src_d   = SRC_ALARM;
        end else if (expired) begin
          state_d = state_q == ST_OFF ? ST_ON : nb_q == nbeep ? ST_GAP : ST_OFF;
          nb_d    = state_q == ST_ON && nb_q != nbeep ? nb_q + 4'd1 : nb_q;
        end
      ST_GAP:
        if (req_q[0] && src_q != SRC_ALARM) begin
          state_d = ST_ALARM;
          src_d   = SRC_ALARM;
        end else if (expired) begin
          state_d = ST_IDLE;
          done_d  = src_q == SRC_ALARM ? 3'b000 : 3'b001 << src_q;
        end
      ST_ALARM: state_d = req_q[0] ? ST_ALARM : ST_GAP;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstb) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_ALARM;
      nb_q     <= '0;
      ms_q     <= '0;
      req_q    <= '0;
      pend_q   <= '0;
      tone_en  <= 1'b0;
      tone_sel <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      nb_q     <= nb_d;
      ms_q     <= ms_d;
      req_q    <= req;
      pend_q   <= pend_d;
      tone_en  <= state_d == ST_ON || state_d == ST_ALARM;
      tone_sel <= state_d == ST_IDLE ? 2'd0 : src_d;
      grant    <= state_d == ST_IDLE ? 3'b000 : 3'b001 << src_d;
      busy     <= state_d != ST_IDLE;
      done     <= done_d;
    end
endmodule

// File: tb/tb_sound_sched.sv
// tb_sound_sched: per-cycle expected output traces are queued as stimulus is driven and compared at each negedge.
module tb_sound_sched;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [2:0] req = 3'b000;
  logic       tone_en, busy;
  logic [1:0] tone_sel;
  logic [2:0] grant, done;
  always #5 clk = ~clk;
  sound_sched #(
    .C_CLK_FRQ(10_000),
    .C_ON_MS  (2),
    .C_OFF_MS (1),
    .C_GAP_MS (3),
    .C_NBEEP_1(3),
    .C_NBEEP_2(1)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .req     (req),
    .tone_en (tone_en),
    .tone_sel(tone_sel),
    .grant   (grant),
    .busy    (busy),
    .done    (done)
  );
  typedef struct {
    int         n;
    logic [9:0] o;
  } seg_t;
  seg_t       b1[7];
  seg_t       b2[3];
  logic [9:0] exp_q[$];
  logic [9:0] idle, alarm, gap_a;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  string      tname = "reset";
  function automatic logic [9:0] pk(logic en, logic [2:0] gr, logic [1:0] sel, logic by, logic [2:0] dn);
    return {en, gr, sel, by, dn};
  endfunction
  task automatic push(int n, logic [9:0] o);
    repeat (n) exp_q.push_back(o);
  endtask
  task automatic push_b1();
    foreach (b1[i]) push(b1[i].n, b1[i].o);
  endtask
  task automatic push_b2();
    foreach (b2[i]) push(b2[i].n, b2[i].o);
  endtask
  task automatic step();
    logic [9:0] e, a;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tone_en, grant, tone_sel, busy, done};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got en/grant/sel/busy/done=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 tname, cyc, a[9], a[8:6], a[5:4], a[3], a[2:0], e[9], e[8:6], e[5:4], e[3], e[2:0]);
      end
    end
  endtask
  task automatic steps(int n);
    repeat (n) step();
  endtask
  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask
  initial begin
    idle  = pk(1'b0, 3'b000, 2'd0, 1'b0, 3'b000);
    alarm = pk(1'b1, 3'b001, 2'd0, 1'b1, 3'b000);
    gap_a = pk(1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
    b1[0] = '{20, pk(1'b1, 3'b010, 2'd1, 1'b1, 3'b000)};
    b1[1] = '{10, pk(1'b0, 3'b010, 2'd1, 1'b1, 3'b000)};
    b1[2] = '{20, pk(1'b1, 3'b010, 2'd1, 1'b1, 3'b000)};
    b1[3] = '{10, pk(1'b0, 3'b010, 2'd1, 1'b1, 3'b000)};
    b1[4] = '{20, pk(1'b1, 3'b010, 2'd1, 1'b1, 3'b000)};
    b1[5] = '{30, pk(1'b0, 3'b010, 2'd1, 1'b1, 3'b000)};
    b1[6] = '{1,  pk(1'b0, 3'b000, 2'd0, 1'b0, 3'b010)};
    b2[0] = '{20, pk(1'b1, 3'b100, 2'd2, 1'b1, 3'b000)};
    b2[1] = '{30, pk(1'b0, 3'b100, 2'd2, 1'b1, 3'b000)};
    b2[2] = '{1,  pk(1'b0, 3'b000, 2'd0, 1'b0, 3'b100)};
    push(3, idle);
    steps(3);
    rstb = 1'b1;
    push(3, idle);
    drain();
    tname = "walk_burst";
    req = 3'b010;
    push(1, idle);
    push_b1();
    push(5, idle);
    step();
    req = 3'b000;
    drain();
    tname = "walk_ack_same_cycle";
    req = 3'b110;
    push(1, idle);
    push_b1();
    push_b2();
    push(5, idle);
    step();
    req = 3'b000;
    drain();
    tname = "alarm_preempt";
    req = 3'b100;
    push(1, idle);
    push(6, b2[0].o);
    push(50, alarm);
    push(30, gap_a);
    push(10, idle);
    step();
    req = 3'b000;
    steps(5);
    req = 3'b001;
    steps(50);
    req = 3'b000;
    drain();
    tname = "reset_mid_off";
    req = 3'b010;
    push(1, idle);
    push(20, b1[0].o);
    push(5, b1[1].o);
    push(101, idle);
    step();
    req = 3'b000;
    steps(8);
    req = 3'b100;
    step();
    req = 3'b000;
    steps(16);
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    drain();
    tname = "walk_requeue";
    req = 3'b010;
    push(1, idle);
    push_b1();
    push_b1();
    push(5, idle);
    step();
    req = 3'b000;
    steps(24);
    req = 3'b010;
    step();
    req = 3'b000;
    drain();
    tname = "ack_held";
    req = 3'b100;
    push(1, idle);
    push_b2();
    push(448, idle);
    steps(500);
    req = 3'b000;
    push(5, idle);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sound_sched.md
Name: sound_sched

Overview:
Sequencer/arbiter in front of the tone generator (`sound`) instances in the traffic-light design. It takes beep requests from three sources: alarm, pedestrian-walk and pedestrian-request-acknowledge. It chooses one source at a time and drives the tone generator enable with an on/off cadence. It also outputs which source's tone the top level must route to the speaker.

Parameters:
C_CLK_FRQ, 100_000_000, clock frequency [Hz]; must be a multiple of 1000.
C_ON_MS, 200, beep on-time [ms].
C_OFF_MS, 200, off-time between beeps of one burst [ms].
C_GAP_MS, 500, silent gap after each burst or alarm [ms].
C_NBEEP_1, 3, beeps per burst for source 1; range 1..15.
C_NBEEP_2, 1, beeps per burst for source 2; range 1..15.

Ports:
clk  input  1  master clock.
rstb  input  1  reset; synchronous, active-low.
req  input  3  [0] alarm (level), [1] walk (edge), [2] acknowledge (edge).
tone_en  output  1  drives `sound` input `in`.
tone_sel  output  2  index of the granted source; 0 when idle.
grant  output  3  one-hot granted source; 0 when idle.
busy  output  1  1 in any state other than IDLE.
done  output  3  one-cycle pulse when a burst on source i completes.

Behaviour:
- Ms prescaler: period C_CLK_FRQ/1000 cycles. It restarts on every state entry, so each state lasts exactly N_ms*C_CLK_FRQ/1000 cycles.
- Edge capture:
  - req_q registers req.
  - req[i] & ~req_q[i] sets pend[i], for i = 1, 2.
  - pend[i] clears on the cycle its burst is granted.
  - An edge during source i's own burst sets pend[i] again, which queues one more burst.
  - Multiple edges while pending collapse into one burst.
- States: IDLE, ON, OFF, GAP, ALARM. Transitions:
  - IDLE: req[0]=1 -> ALARM. Else pend[1] -> ON (src 1). Else pend[2] -> ON (src 2). Fixed priority 0 > 1 > 2.
  - ON: tone_en=1 for C_ON_MS. At expiry: if the beep count equals C_NBEEP_src -> GAP, else OFF and increment the count.
  - OFF: tone_en=0 for C_OFF_MS, then -> ON.
  - ALARM: tone_en=1 continuously while req[0]=1. When req[0]=0 -> GAP with src 0.
  - GAP: tone_en=0 for C_GAP_MS. At expiry: done[src] pulses for one cycle if src is 1 or 2 and the burst was not aborted, then -> IDLE.
- Preemption:
  - req[0]=1 in ON, OFF or GAP of source 1/2 -> ALARM on the next edge.
  - The interrupted burst is aborted: no done pulse, no re-queue.
  - Bursts are never preempted by sources 1 or 2.
- Latency: from the first clk edge sampling a req rise in IDLE, tone_en/grant/tone_sel/busy are high after the second edge. Same for the alarm.
- All outputs are registered.
- grant/tone_sel hold the current source through ON, OFF, GAP and ALARM.
- Reset (rstb=0 at a clk edge, including mid-burst):
  - State IDLE; pend, req_q, counters and prescaler cleared.
  - tone_en=0, tone_sel=0, grant=0, busy=0, done=0.
  - A req held high across reset release counts as a new edge.
- Beep counter is 4 bits and never wraps past C_NBEEP (1..15).

Decomposition:
- Package sound_pkg:
  - State encoding localparams.
  - Source indices SRC_ALARM=0, SRC_WALK=1, SRC_ACK=2.
  - Ms divisor function C_CLK_FRQ/1000 and counter width derivation.
- Sub-module ms_tick: prescaler with synchronous restart, one-cycle tick output.
- FSM, pend logic and output registers stay in sound_sched.

Test Plan:
Common settings: C_CLK_FRQ=10_000 (10 cycles/ms), ON=2, OFF=1, GAP=3, NBEEP_1=3, NBEEP_2=1.
1. One-cycle req[1] pulse from IDLE -> tone_en high for three 20-cycle windows separated by 10-cycle lows, then 30 low cycles. grant=010 and tone_sel=1 throughout. done[1] high for exactly 1 cycle, then busy=0.
2. req[1] and req[2] rise in the same cycle -> full source-1 burst and done[1], then the source-2 single 20-cycle beep, 30-cycle gap, done[2]. grant goes 010 then 100.
3. req[0] raised 5 cycles into a source-2 ON and held 50 cycles -> two edges later grant=001 and tone_sel=0, tone_en continuously 1. On release: 30-cycle gap, no done[2] pulse, then IDLE.
4. rstb=0 for 1 cycle in the middle of a source-1 OFF phase -> after that edge all outputs are 0 and state is IDLE. A pend[2] set before reset is lost: no later burst.
5. Second req[1] edge during source-1 OFF -> after done[1], a second identical 3-beep burst starts with the 2-edge latency from IDLE.
6. req[2] held high for 500 cycles -> exactly one burst and one done[2]; no further bursts while it stays high.
